// File: rtl/pf_lanectrl_pause_arbiter.sv
`timescale 1ns/1ps
// Round-robin owner of the lane HS_IO_CLK_PAUSE: one requester at a time, framed by PRE setup and POST recovery.
// Latency: pause 1 cycle after REQ in IDLE, GNT PRE_CYCLES later; release 1 cycle after DONE/REQ drop.
// Backpressure: requesters hold REQ until served; new requests wait through PRE/GRANT/POST. Option: PF_LANECTRL_PAUSE_ARB_TIMEOUT_EN adds a GRANT watchdog.
module pf_lanectrl_pause_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int PRE_CYCLES     = 4,
   parameter int POST_CYCLES    = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [NUM_REQ-1:0] REQ,
   input  logic [NUM_REQ-1:0] DONE,
   output logic [NUM_REQ-1:0] GNT,
   output logic               HS_IO_CLK_PAUSE,
   output logic               BUSY,
   output logic               TIMEOUT_ERR
);

   localparam int SELW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PRE   = 2'd1;
   localparam logic [1:0] ST_GRANT = 2'd2;
   localparam logic [1:0] ST_POST  = 2'd3;

   localparam logic [7:0] PRE_LOAD  = 8'(PRE_CYCLES - 1);
   localparam logic [7:0] POST_LOAD = 8'(POST_CYCLES - 1);
   // Loaded on GRANT entry in every build; only the watchdog build ever looks at it in GRANT.
   localparam logic [7:0] TMO_LOAD  = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

   logic [1:0]         state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [SELW-1:0]    sel_q, sel_d;
   logic [SELW-1:0]    last_q, last_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               pause_q, pause_d;
   logic               err_q, err_d;
   logic [SELW-1:0]    win;
   logic [SELW-1:0]    cand;
   logic               found;
   logic               sel_req;
   logic               sel_done;

   assign sel_req  = REQ[sel_q];
   assign sel_done = DONE[sel_q];

   // Round-robin winner: first requester above last_q, wrapping around.
   always_comb begin
      win   = last_q;
      cand  = last_q;
      found = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = SELW'((int'(last_q) + i) % NUM_REQ);
         if (!found && REQ[cand]) begin
            win   = cand;
            found = 1'b1;
         end
      end
   end

   // Next-state logic for the IDLE/PRE/GRANT/POST sequence and the shared counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      pause_d = pause_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (|REQ) begin
               sel_d   = win;
               cnt_d   = PRE_LOAD;
               pause_d = 1'b1;
               state_d = ST_PRE;
            end
         end
         ST_PRE: begin
            // Abort takes priority: the requester left before being granted, so
            // the pointer is not advanced and it keeps its turn.
            if (!sel_req) begin
               pause_d = 1'b0;
               cnt_d   = POST_LOAD;
               state_d = ST_POST;
            end else if (cnt_q == 8'd0) begin
               gnt_d   = ONE << sel_q;
               cnt_d   = TMO_LOAD;
               state_d = ST_GRANT;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_GRANT: begin
            if (sel_done || !sel_req) begin
               gnt_d   = '0;
               pause_d = 1'b0;
               last_d  = sel_q;
               cnt_d   = POST_LOAD;
               state_d = ST_POST;
            end
`ifdef PF_LANECTRL_PAUSE_ARB_TIMEOUT_EN
            else if (cnt_q == 8'd0) begin
               gnt_d   = '0;
               pause_d = 1'b0;
               last_d  = sel_q;
               err_d   = 1'b1;
               cnt_d   = POST_LOAD;
               state_d = ST_POST;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
`endif
         end
         default: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
      endcase
   end

   // State registers; reset parks the pointer so requester 0 wins first.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
         sel_q   <= '0;
         last_q  <= SELW'(NUM_REQ - 1);
         gnt_q   <= '0;
         pause_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         pause_q <= pause_d;
      end
   end

`ifdef PF_LANECTRL_PAUSE_ARB_TIMEOUT_EN
   // Sticky watchdog flag, cleared only by reset.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
`else
   assign err_q = 1'b0;
`endif

   assign GNT             = gnt_q;
   assign HS_IO_CLK_PAUSE = pause_q;
   assign BUSY            = (state_q != ST_IDLE);
   assign TIMEOUT_ERR     = err_q;

endmodule
